// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path types and constants for the fetch_unit slice.
package fetch_unit_pkg;

  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_DATA_W = 16;
  localparam int PC_STEP      = 2;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; used for both the prefetch queue and the PC tag FIFO.
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order memory requests, buffers words for stage_one.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              stall,
  input  logic              halt_sys,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0]     inflight;
  logic [PW-1:0]     inflight_next;
  logic [PW-1:0]     drop;
  logic [PW-1:0]     q_count;
  logic [PW-1:0]     tag_count;
  logic [PW:0]       used;
  logic [EW-1:0]     q_rdata;
  logic [ADDR_W-1:0] tag_pc;
  logic              req_fire;
  logic              rsp_ok;
  logic              keep;
  logic              q_pop;

  // Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // a response is a single-cycle imem_rsp_valid pulse, in request order, with no back-pressure.
  // Credit counts queued plus outstanding words so a response always finds a free slot.
  assign used           = {1'b0, q_count} + {1'b0, inflight};
  assign imem_req_valid = !rst && !halt_sys && !redirect_en && (int'(used) < DEPTH);
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with no outstanding request (e.g. one straddling reset) is ignored.
  assign rsp_ok         = imem_rsp_valid && (tag_count != '0);
  assign keep           = rsp_ok && (drop == '0) && !redirect_en;
  assign inflight_next  = inflight + PW'(req_fire) - PW'(rsp_ok);

  assign out_valid      = (q_count != '0) && !halt_sys;
  assign q_pop          = out_valid && !stall;
  assign out_pc         = q_rdata[EW-1:DATA_W];
  assign out_instr      = q_rdata[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect_en) begin
        fetch_pc <= redirect_pc;
        drop     <= inflight_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (rsp_ok && (drop != '0)) drop <= drop - PW'(1);
      end
    end
  end

  fetch_queue #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (rsp_ok),
    .rdata (tag_pc),
    .count (tag_count)
  );

  fetch_queue #(.W(EW), .DEPTH(DEPTH)) u_prefetch_q (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_en),
    .push  (keep),
    .wdata ({tag_pc, imem_rsp_data}),
    .pop   (q_pop),
    .rdata (q_rdata),
    .count (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with configurable latency plus an in-order scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        stall;
  logic        halt_sys;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] XOR_KEY  = 16'hA5A5;

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(2), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .halt_sys       (halt_sys),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  logic        rsp_driven;
  logic [15:0] exp_fetch_pc;
  logic [15:0] exp_q[$];
  logic [15:0] mem_addr_q[$];
  int          mem_due_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // driver + monitor for one clock cycle
  task automatic step(input logic st, input logic hl, input logic rd, input logic [15:0] rpc,
                      input logic rdy);
    logic [15:0] e;
    @(negedge clk);
    stall          = st;
    halt_sys       = hl;
    redirect_en    = rd;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    rsp_driven     = 1'b0;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_addr_q.pop_front() ^ XOR_KEY;
      void'(mem_due_q.pop_front());
      rsp_driven     = 1'b1;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'h0000;
    end
    #1;
    if (out_valid && !st && !rd) begin
      if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_instr", out_instr, e ^ XOR_KEY);
      end
    end
    if (rd) begin
      check("req_during_redirect", imem_req_valid, 0);
      exp_q.delete();
      exp_fetch_pc = rpc;
    end else if (imem_req_valid && rdy) begin
      check("fetch_addr", imem_addr, exp_fetch_pc);
      exp_q.push_back(exp_fetch_pc);
      exp_fetch_pc = exp_fetch_pc + 16'd2;
      mem_addr_q.push_back(imem_addr);
      mem_due_q.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [15:0] stall_instr;
    stall          = 1'b0;
    halt_sys       = 1'b0;
    redirect_en    = 1'b0;
    redirect_pc    = 16'h0000;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0000;
    exp_fetch_pc   = RESET_PC;
    stall_instr    = 16'h0004 ^ XOR_KEY;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    rst = 1'b0;

    // zero-wait memory stream up to pc 4
    lat = 1;
    for (int i = 0; i < 50 && !(out_valid && out_pc == 16'h0004); i++) step(0, 0, 0, 16'h0, 1);
    check("reach_pc4", out_pc, 16'h0004);

    // stall at pc 4 for five cycles
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 16'h0, 1);
      check("stall_valid", out_valid, 1);
      check("stall_pc", out_pc, 16'h0004);
      check("stall_instr", out_instr, stall_instr);
    end
    check("stall_credit_full", imem_req_valid, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0, 1);

    // halt mid-stream
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 16'h0, 1);
      check("halt_out_valid", out_valid, 0);
      check("halt_req_valid", imem_req_valid, 0);
    end
    for (int i = 0; i < 15; i++) step(0, 0, 0, 16'h0, 1);

    // latency 3, redirect with two requests outstanding
    lat = 3;
    for (int i = 0; i < 40 && mem_addr_q.size() != 2; i++) step(0, 0, 0, 16'h0, 1);
    check("inflight_two", mem_addr_q.size(), 2);
    step(0, 0, 1, 16'h0100, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0, 1);

    // redirect coinciding with a response and a stall
    lat = 1;
    for (int i = 0; i < 20 && mem_addr_q.size() == 0; i++) step(0, 0, 0, 16'h0, 1);
    step(1, 0, 1, 16'h0200, 1);
    check("redir_rsp_seen", rsp_driven, 1);
    check("redir_q_empty", out_valid, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0, 1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic st, hl, rd, rdy;
      logic [15:0] rpc;
      if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 3);
      st  = ($urandom_range(0, 3) == 0);
      hl  = ($urandom_range(0, 9) == 0);
      rd  = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = 16'($urandom_range(0, 32767) * 2);
      step(st, hl, rd, rpc, rdy);
    end

    // asynchronous reset mid-burst
    lat = 2;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_pc", out_pc, 0);
    check("async_rst_out_instr", out_instr, 0);
    check("async_rst_req_valid", imem_req_valid, 0);
    exp_q.delete();
    exp_fetch_pc = RESET_PC;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0, 1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0, 1);

    // drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(0, 0, 0, 16'h0, 0);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
